// File: rtl/bus_monitor_pkg.sv
// Shared definitions for the bus activity monitor: FSM encoding, sticky
// error bit positions and the default watchdog limit.
package bus_monitor_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_BUSERR  = 1;
  localparam int ERR_BEATS   = 2;
  localparam int ERR_REBEGIN = 3;

  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/bus_activity_monitor_counter.sv
// Generic free-running counter with synchronous clear (priority) and enable.
module bus_activity_monitor_counter #(
  parameter int WIDTH    = 16,
  parameter bit COUNT_UP = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      count <= COUNT_UP ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/bus_activity_monitor.sv
// Watches the bus begin/end handshake, produces a registered busIdle for the
// profiler, counts beats and completed transactions, and flags anomalies.
module bus_activity_monitor
  import bus_monitor_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   beginTransactionIn,
  input  logic                   endTransactionIn,
  input  logic                   dataValidIn,
  input  logic [7:0]             burstSizeIn,
  input  logic                   busErrorIn,
  input  logic                   clearErrorsIn,
  output logic                   busIdle,
  output logic [8:0]             beatCount,
  output logic [COUNT_WIDTH-1:0] transactionCount,
  output logic                   timeoutPulse,
  output logic [3:0]             errorFlags
);

  localparam logic [15:0] WATCHDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]  BEATS_MAX     = 9'd511;

  state_t      state, state_next;
  logic [15:0] watchdog;
  logic [8:0]  beats, beats_now, expected;
  logic        accept_begin, exit_end, exit_err, exit_timeout, exit_active;
  logic [3:0]  err_set;

  // Beat total including a beat transferred in the current cycle.
  assign beats_now = (dataValidIn && beats != BEATS_MAX) ? beats + 9'd1 : beats;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    accept_begin = 1'b0;
    exit_end     = 1'b0;
    exit_err     = 1'b0;
    exit_timeout = 1'b0;
    err_set      = '0;
    case (state)
      IDLE: begin
        if (beginTransactionIn) begin
          accept_begin = 1'b1;
          state_next   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (beginTransactionIn) err_set[ERR_REBEGIN] = 1'b1;
        if (endTransactionIn) begin
          exit_end   = 1'b1;
          state_next = IDLE;
          if (beats_now != expected) err_set[ERR_BEATS] = 1'b1;
        end else if (busErrorIn) begin
          exit_err            = 1'b1;
          state_next          = IDLE;
          err_set[ERR_BUSERR] = 1'b1;
        end else if (watchdog == WATCHDOG_LAST) begin
          exit_timeout         = 1'b1;
          state_next           = IDLE;
          err_set[ERR_TIMEOUT] = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign exit_active = exit_end | exit_err | exit_timeout;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The state flop itself is the registered idle indication.
  assign busIdle = (state == IDLE);

  bus_activity_monitor_counter #(
    .WIDTH    (16),
    .COUNT_UP (1'b1)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset | exit_active | accept_begin),
    .enable (state == ACTIVE),
    .count  (watchdog)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      beats            <= '0;
      expected         <= '0;
      beatCount        <= '0;
      transactionCount <= '0;
      timeoutPulse     <= 1'b0;
      errorFlags       <= '0;
    end else begin
      timeoutPulse <= exit_timeout;
      if (accept_begin) begin
        expected <= {1'b0, burstSizeIn} + 9'd1;
        beats    <= '0;
      end else if (state == ACTIVE) begin
        beats <= beats_now;
      end
      if (exit_active) beatCount <= beats_now;
      if (exit_end) transactionCount <= transactionCount + COUNT_WIDTH'(1);
      // A bit being set in the same cycle as a clear survives the clear.
      errorFlags <= clearErrorsIn ? err_set : (errorFlags | err_set);
    end
  end

endmodule

// File: tb/tb_bus_activity_monitor.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// every cycle against a transaction-level reference model.
module tb_bus_activity_monitor;

  localparam int T  = 16;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset, beginTransactionIn, endTransactionIn, dataValidIn;
  logic [7:0]    burstSizeIn;
  logic          busErrorIn, clearErrorsIn;
  logic          busIdle, timeoutPulse;
  logic [8:0]    beatCount;
  logic [CW-1:0] transactionCount;
  logic [3:0]    errorFlags;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit            m_active;
  int            m_beats, m_age, m_exp;
  logic [8:0]    m_beat_count;
  logic [CW-1:0] m_tc;
  logic          m_pulse;
  logic [3:0]    m_flags;

  bus_activity_monitor #(.TIMEOUT_CYCLES(T), .COUNT_WIDTH(CW)) dut (
    .clock              (clock),
    .reset              (reset),
    .beginTransactionIn (beginTransactionIn),
    .endTransactionIn   (endTransactionIn),
    .dataValidIn        (dataValidIn),
    .burstSizeIn        (burstSizeIn),
    .busErrorIn         (busErrorIn),
    .clearErrorsIn      (clearErrorsIn),
    .busIdle            (busIdle),
    .beatCount          (beatCount),
    .transactionCount   (transactionCount),
    .timeoutPulse       (timeoutPulse),
    .errorFlags         (errorFlags)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  // One clock of the specification's rules applied to the sampled inputs.
  task automatic model_update();
    logic [3:0] set;
    int b;
    set = '0;
    if (reset) begin
      m_active = 0; m_beats = 0; m_age = 0; m_exp = 0;
      m_beat_count = '0; m_tc = '0; m_pulse = 0; m_flags = '0;
      return;
    end
    m_pulse = 0;
    if (!m_active) begin
      if (beginTransactionIn) begin
        m_active = 1; m_exp = int'(burstSizeIn) + 1; m_beats = 0; m_age = 0;
      end
    end else begin
      b = m_beats + (dataValidIn ? 1 : 0);
      if (b > 511) b = 511;
      if (beginTransactionIn) set[3] = 1'b1;
      if (endTransactionIn) begin
        m_active = 0; m_beat_count = 9'(b); m_tc = m_tc + 1'b1;
        if (b != m_exp) set[2] = 1'b1;
      end else if (busErrorIn) begin
        m_active = 0; m_beat_count = 9'(b); set[1] = 1'b1;
      end else if (m_age == T - 1) begin
        m_active = 0; m_beat_count = 9'(b); set[0] = 1'b1; m_pulse = 1;
      end else begin
        m_beats = b; m_age++;
      end
    end
    m_flags = clearErrorsIn ? set : (m_flags | set);
  endtask

  task automatic cyc(input logic b, input logic e, input logic dv, input logic [7:0] bs,
                     input logic err, input logic clr, input logic rst);
    beginTransactionIn = b; endTransactionIn = e; dataValidIn = dv;
    burstSizeIn = bs; busErrorIn = err; clearErrorsIn = clr; reset = rst;
    @(posedge clock);
    model_update();
    #1;
    check("busIdle", 64'(busIdle), 64'(!m_active));
    check("beatCount", 64'(beatCount), 64'(m_beat_count));
    check("transactionCount", 64'(transactionCount), 64'(m_tc));
    check("timeoutPulse", 64'(timeoutPulse), 64'(m_pulse));
    check("errorFlags", 64'(errorFlags), 64'(m_flags));
  endtask

  task automatic idle();
    cyc(0, 0, 0, 8'd0, 0, 0, 0);
  endtask

  initial begin
    logic [CW-1:0] tc_before;
    // Reset and quiet bus.
    cyc(0, 0, 0, 8'd0, 0, 0, 1);
    cyc(0, 0, 0, 8'd0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      idle();
      check("reset_idle", 64'({busIdle, beatCount, transactionCount, timeoutPulse, errorFlags}),
            64'({1'b1, 9'd0, 8'd0, 1'b0, 4'd0}));
    end

    // Four beats, burst size 3: clean completion.
    cyc(1, 0, 0, 8'd3, 0, 0, 0);
    check("busy_after_begin", 64'(busIdle), 64'd0);
    cyc(0, 0, 1, 8'd0, 0, 0, 0);
    cyc(0, 0, 1, 8'd0, 0, 0, 0);
    cyc(0, 0, 1, 8'd0, 0, 0, 0);
    cyc(0, 1, 1, 8'd0, 0, 0, 0);
    check("clean_result", 64'({busIdle, beatCount, transactionCount, errorFlags}),
          64'({1'b1, 9'd4, 8'd1, 4'd0}));

    // Five beats against an expected eight: beat mismatch, then clear.
    cyc(1, 0, 0, 8'd7, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'd0, 0, 0, 0);
    cyc(0, 1, 1, 8'd0, 0, 0, 0);
    check("mismatch_result", 64'({beatCount, transactionCount, errorFlags}),
          64'({9'd5, 8'd2, 4'b0100}));
    cyc(0, 0, 0, 8'd0, 0, 1, 0);
    check("cleared", 64'(errorFlags), 64'd0);

    // Watchdog: pulse appears on the 16th cycle after ACTIVE entry.
    cyc(1, 0, 0, 8'd0, 0, 0, 0);
    for (int i = 0; i < T - 1; i++) begin
      idle();
      check("no_early_pulse", 64'(timeoutPulse), 64'd0);
    end
    idle();
    check("timeout_result", 64'({timeoutPulse, busIdle, errorFlags, transactionCount}),
          64'({1'b1, 1'b1, 4'b0001, 8'd2}));
    idle();
    check("pulse_one_cycle", 64'(timeoutPulse), 64'd0);

    // End, bus error and re-begin together; then immediate begin accepted.
    cyc(0, 0, 0, 8'd0, 0, 1, 0);
    cyc(1, 0, 0, 8'd0, 0, 0, 0);
    cyc(1, 1, 1, 8'd0, 1, 0, 0);
    check("coincide_result", 64'({busIdle, transactionCount, errorFlags, beatCount}),
          64'({1'b1, 8'd3, 4'b1000, 9'd1}));
    cyc(1, 0, 0, 8'd1, 0, 0, 0);
    check("back_to_back", 64'(busIdle), 64'd0);
    cyc(0, 0, 1, 8'd0, 0, 0, 0);
    cyc(0, 1, 1, 8'd0, 0, 0, 0);

    // Reset in mid-transaction.
    cyc(1, 0, 0, 8'd5, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'd0, 0, 0, 0);
    cyc(0, 0, 0, 8'd0, 0, 0, 1);
    check("mid_reset", 64'({busIdle, beatCount, transactionCount, errorFlags}),
          64'({1'b1, 9'd0, 8'd0, 4'd0}));

    // Counter wrap: 256 single-beat transactions return to the start value.
    idle();
    tc_before = transactionCount;
    for (int i = 0; i < 256; i++) begin
      cyc(1, 0, 0, 8'd0, 0, 0, 0);
      cyc(0, 1, 1, 8'd0, 0, 0, 0);
    end
    check("wrap", 64'(transactionCount), 64'(tc_before));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), 1'($urandom),
          8'($urandom_range(0, 6)), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_activity_monitor.md
Name: bus_activity_monitor

Overview:
- Upstream neighbour of the profiling custom instruction: watches the shared-bus transaction handshake and produces the registered busIdle signal that the profiler's bus-idle counter consumes.
- Also tracks data beats per transaction, detects protocol anomalies with a transaction watchdog, and keeps a completed-transaction count readable by software.
- Sits between the bus arbiter/handshake signals and the profiler's busIdle input.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles a transaction may stay active before the watchdog aborts it; legal range 2..65535.
- COUNT_WIDTH, 32, width of transactionCount.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- beginTransactionIn  input  1  single-cycle pulse, start of a bus transaction
- endTransactionIn  input  1  single-cycle pulse, end of a bus transaction
- dataValidIn  input  1  one data beat transferred this cycle
- burstSizeIn  input  8  beats minus one; sampled with beginTransactionIn
- busErrorIn  input  1  slave/arbiter error, aborts transaction
- clearErrorsIn  input  1  clears sticky errorFlags
- busIdle  output  1  high while no transaction is active (registered)
- beatCount  output  9  beats counted in last completed or aborted transaction
- transactionCount  output  COUNT_WIDTH  completed transactions, wraps modulo 2^COUNT_WIDTH
- timeoutPulse  output  1  one-cycle pulse when watchdog aborts
- errorFlags  output  4  sticky: [0] timeout, [1] busError, [2] beat mismatch, [3] begin while active

Behaviour:
- Reset, synchronous, active-high, highest priority: state IDLE, busIdle=1, beatCount=0, transactionCount=0, timeoutPulse=0, errorFlags=0, internal beat/watchdog counters 0.
- Reset mid-transaction aborts it silently: no error flags, no count increment.
- FSM states: IDLE, ACTIVE.
- IDLE + beginTransactionIn:
  - go ACTIVE next cycle.
  - latch expected = burstSizeIn+1 (9 bits).
  - clear beat and watchdog counters.
  - busIdle falls the cycle after the begin pulse, so the begin cycle itself still counts as idle.
- In IDLE, dataValidIn and endTransactionIn are ignored.
- ACTIVE, per cycle:
  - the beat counter increments on dataValidIn, saturating at 511.
  - the watchdog increments by 1 each cycle.
- ACTIVE exit priority, highest first:
  - endTransactionIn: go IDLE, beatCount <= beats including the current-cycle beat, transactionCount += 1; if beats != expected, set errorFlags[2].
  - busErrorIn: go IDLE, set errorFlags[1], latch beatCount, no count increment.
  - watchdog == TIMEOUT_CYCLES-1: go IDLE, timeoutPulse=1 for exactly one cycle, set errorFlags[0], latch beatCount, no count increment.
- If end, busError and timeout coincide, end wins; busError and timeout then have no effect.
- beginTransactionIn while ACTIVE: set errorFlags[3] and otherwise ignore it; no restart and no relatch. This also applies when it coincides with end or abort.
- busIdle rises the cycle after any exit from ACTIVE.
- Back-to-back transactions: a begin in the cycle after end is accepted normally; busIdle is high for exactly that one cycle.
- errorFlags: set has priority over clearErrorsIn in the same cycle; all other bits clear.
- transactionCount wraps from all-ones to 0 with no flag.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package bus_monitor_pkg holds:
  - the state encoding (IDLE=1'b0, ACTIVE=1'b1).
  - error bit indices ERR_TIMEOUT=0, ERR_BUSERR=1, ERR_BEATS=2, ERR_REBEGIN=3.
  - the default TIMEOUT_CYCLES constant.
- The watchdog reuses the team's existing counter module: width 16, direction up, enable = ACTIVE, reset = reset or ACTIVE-exit or begin-accept.
- The transaction and beat counters stay inline.

Test Plan:
- Reset then idle 10 cycles -> busIdle=1 throughout, all outputs 0, errorFlags=0.
- begin with burstSizeIn=3, 4 dataValid beats, end on the 4th beat -> busIdle low from cycle after begin until cycle after end, beatCount=4, transactionCount=1, errorFlags=0.
- begin with burstSizeIn=7, 5 beats, end -> beatCount=5, errorFlags=4'b0100, transactionCount increments; clearErrorsIn next cycle -> errorFlags=0.
- TIMEOUT_CYCLES=16, begin, no end -> timeoutPulse high exactly one cycle 16 cycles after ACTIVE entry, errorFlags[0]=1, busIdle returns high, transactionCount unchanged.
- End, busErrorIn and a second begin in the same ACTIVE cycle -> normal completion counted, errorFlags=4'b1000, then IDLE; begin next cycle accepted.
- Reset asserted mid-transaction after 3 beats -> next cycle busIdle=1, beatCount=0, transactionCount=0, errorFlags=0.
